// File: rtl/outdata.sv
// outdata: transmit-side serializer for the FP multiplier datapath.
// Takes one 8*NUM_BYTES-bit word on a DataValid strobe and sends it
// as NUM_BYTES bytes, most significant byte first, over a valid/ready
// byte interface toward the UART transmitter.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   DataValid  one-cycle strobe qualifying Result (honoured when in_ready=1)
//   Result     word to send, sampled on the accepting edge
//   in_ready   1 while idle and able to accept a word
//   tx_data    current byte
//   tx_valid   tx_data valid, held until accepted
//   tx_ready   downstream accepts a byte on tx_valid & tx_ready
//   tx_last    1 while the final byte of a word is presented
//   done       one-cycle pulse after the last byte is accepted
//   overrun    sticky: DataValid arrived while busy
module outdata #(
    parameter int unsigned NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   DataValid,
    input  logic [8*NUM_BYTES-1:0] Result,
    output logic                   in_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   done,
    output logic                   overrun
);

    localparam int unsigned W     = 8 * NUM_BYTES;
    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q,    state_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [W-1:0]     shift_q,    shift_d;
    logic [7:0]       tx_data_q,  tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q,  tx_last_d;
    logic             done_q,     done_d;
    logic             overrun_q,  overrun_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;

        case (state_q)
            IDLE: begin
                if (DataValid) begin
                    state_d    = SEND;
                    shift_d    = Result;
                    idx_d      = '0;
                    tx_data_d  = Result[W-1 -: 8];
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                end
            end
            SEND: begin
                // Any strobe while busy is dropped, including the final-accept cycle
                if (DataValid) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = IDLE;
                        idx_d      = '0;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        // Shift so the next byte always sits in the top lane
                        idx_d     = idx_q + IDX_W'(1);
                        shift_d   = shift_q << 8;
                        tx_data_d = shift_q[W-9 -: 8];
                        tx_last_d = (idx_d == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_outdata.sv
// tb_outdata: scoreboard bench for outdata with NUM_BYTES=4 and NUM_BYTES=8.
module tb_outdata;

    logic        clk = 1'b0;
    logic        rst;

    logic        dv4, in_ready4, tx_valid4, tx_ready4, tx_last4, done4, overrun4;
    logic [31:0] res4;
    logic [7:0]  tx_data4;

    logic        dv8, in_ready8, tx_valid8, tx_ready8, tx_last8, done8, overrun8;
    logic [63:0] res8;
    logic [7:0]  tx_data8;

    always #5 clk = ~clk;

    outdata #(.NUM_BYTES(4)) dut4 (
        .clk(clk), .rst(rst), .DataValid(dv4), .Result(res4),
        .in_ready(in_ready4), .tx_data(tx_data4), .tx_valid(tx_valid4),
        .tx_ready(tx_ready4), .tx_last(tx_last4), .done(done4), .overrun(overrun4)
    );

    outdata #(.NUM_BYTES(8)) dut8 (
        .clk(clk), .rst(rst), .DataValid(dv8), .Result(res8),
        .in_ready(in_ready8), .tx_data(tx_data8), .tx_valid(tx_valid8),
        .tx_ready(tx_ready8), .tx_last(tx_last8), .done(done8), .overrun(overrun8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected bytes: {last, data}
    logic [8:0] q4[$];
    logic [8:0] q8[$];

    int acc4 = 0, dones4 = 0, acc8 = 0, dones8 = 0;
    bit stall4 = 0, last_acc4 = 0, last_acc8 = 0;
    logic [7:0] pdata4;
    logic       plast4;

    // Backpressure generator: mode 1 holds tx_ready low 5 cycles per byte
    int rdy_mode = 0;
    int stall_n  = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            tx_ready4 = 1'b1;
        end else if (tx_valid4 && stall_n < 5) begin
            tx_ready4 = 1'b0;
            stall_n++;
        end else begin
            tx_ready4 = 1'b1;
            stall_n   = 0;
        end
    end

    // Monitor for the 4-byte instance, sampled mid-cycle
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            stall4    = 0;
            last_acc4 = 0;
        end else begin
            check_eq("done4_timing", done4, last_acc4);
            if (done4) dones4++;
            if (stall4) begin
                check_eq("hold_valid", tx_valid4, 1);
                check_eq("hold_data", tx_data4, pdata4);
                check_eq("hold_last", tx_last4, plast4);
            end
            last_acc4 = 0;
            if (tx_valid4 && tx_ready4) begin
                acc4++;
                if (q4.size() == 0) begin
                    check_eq("unexpected_byte4", tx_data4, 9'h1ff);
                end else begin
                    e = q4.pop_front();
                    check_eq("byte4", tx_data4, e[7:0]);
                    check_eq("last4", tx_last4, e[8]);
                    last_acc4 = e[8];
                end
            end
            stall4 = tx_valid4 && !tx_ready4;
            pdata4 = tx_data4;
            plast4 = tx_last4;
        end
    end

    // Monitor for the 8-byte instance
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            last_acc8 = 0;
        end else begin
            check_eq("done8_timing", done8, last_acc8);
            if (done8) dones8++;
            last_acc8 = 0;
            if (tx_valid8 && tx_ready8) begin
                acc8++;
                if (q8.size() == 0) begin
                    check_eq("unexpected_byte8", tx_data8, 9'h1ff);
                end else begin
                    e = q8.pop_front();
                    check_eq("byte8", tx_data8, e[7:0]);
                    check_eq("last8", tx_last8, e[8]);
                    last_acc8 = e[8];
                end
            end
        end
    end

    task automatic push4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            q4.push_back({(i == 0), w[8*i +: 8]});
        end
    endtask

    // Pulse DataValid for one cycle; returns at +1 after the latching edge
    task automatic pulse4(input logic [31:0] w);
        dv4  = 1'b1;
        res4 = w;
        @(posedge clk); #1;
        dv4  = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w);
        int n = 0;
        while (!in_ready4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready4) check_eq("in_ready_timeout", in_ready4, 1);
        push4(w);
        pulse4(w);
    endtask

    task automatic wait_done4();
        int n = 0;
        while (!done4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done4) check_eq("done_timeout", done4, 1);
    endtask

    task automatic wait_idle4();
        int n = 0;
        while ((q4.size() != 0 || tx_valid4 || done4) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (q4.size() != 0) check_eq("idle_timeout", 64'(q4.size()), 0);
    endtask

    task automatic check_reset_state4(input string tag);
        check_eq({tag, "_valid"}, tx_valid4, 0);
        check_eq({tag, "_data"}, tx_data4, 0);
        check_eq({tag, "_last"}, tx_last4, 0);
        check_eq({tag, "_done"}, done4, 0);
        check_eq({tag, "_overrun"}, overrun4, 0);
        check_eq({tag, "_in_ready"}, in_ready4, 1);
    endtask

    int a0, d0;

    initial begin
        rst = 1'b1;
        dv4 = 1'b0; res4 = '0; tx_ready4 = 1'b1;
        dv8 = 1'b0; res8 = '0; tx_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state4("rst4");
        check_eq("rst8_valid", tx_valid8, 0);
        check_eq("rst8_in_ready", in_ready8, 1);
        @(posedge clk); #1;

        // Basic word at full rate, first byte one cycle after the strobe
        a0 = acc4; d0 = dones4;
        send4(32'h3FC00000);
        check_eq("basic_first_valid", tx_valid4, 1);
        check_eq("basic_first_data", tx_data4, 8'h3F);
        check_eq("basic_in_ready_busy", in_ready4, 0);
        wait_done4();
        check_eq("basic_in_ready_done", in_ready4, 1);
        wait_idle4();
        check_eq("basic_accepts", acc4 - a0, 4);
        check_eq("basic_dones", dones4 - d0, 1);

        // Backpressure: every byte stalled 5 cycles
        rdy_mode = 1;
        a0 = acc4; d0 = dones4;
        send4(32'hC1480000);
        wait_idle4();
        check_eq("bp_accepts", acc4 - a0, 4);
        check_eq("bp_dones", dones4 - d0, 1);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Overrun during the second byte; dropped word must not appear
        send4(32'hAABBCCDD);
        @(posedge clk); #1;
        check_eq("ovr_second_byte", tx_data4, 8'hBB);
        pulse4(32'h11223344);
        check_eq("ovr_set", overrun4, 1);
        wait_done4();
        // Back-to-back: new word in the done cycle
        check_eq("b2b_in_ready", in_ready4, 1);
        push4(32'h40490FDB);
        pulse4(32'h40490FDB);
        check_eq("b2b_valid", tx_valid4, 1);
        check_eq("b2b_data", tx_data4, 8'h40);
        wait_idle4();
        check_eq("ovr_sticky", overrun4, 1);

        // Reset after two of four bytes
        a0 = acc4; d0 = dones4;
        send4(32'h01020304);
        begin
            int n = 0;
            while (acc4 - a0 < 2 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check_eq("rstmid_accepts", acc4 - a0, 2);
        rst = 1'b1;
        q4.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state4("rstmid");
        repeat (3) @(posedge clk);
        #1;
        check_eq("rstmid_no_done", dones4 - d0, 0);
        send4(32'h0A0B0C0D);
        wait_idle4();
        check_eq("rstmid_new_dones", dones4 - d0, 1);

        // Reset and DataValid together: nothing latched
        @(posedge clk); #1;
        rst = 1'b1;
        dv4 = 1'b1; res4 = 32'hDEADBEEF;
        @(posedge clk); #1;
        rst = 1'b0; dv4 = 1'b0;
        @(negedge clk);
        check_reset_state4("rst_dv");

        // 8-byte instance
        @(posedge clk); #1;
        begin
            logic [63:0] w;
            w = 64'h0123456789ABCDEF;
            for (int i = 7; i >= 0; i--) q8.push_back({(i == 0), w[8*i +: 8]});
            a0 = acc8; d0 = dones8;
            dv8 = 1'b1; res8 = w;
            @(posedge clk); #1;
            dv8 = 1'b0;
            check_eq("w8_first", tx_data8, 8'h01);
            repeat (12) @(posedge clk);
            #1;
            check_eq("w8_accepts", acc8 - a0, 8);
            check_eq("w8_dones", dones8 - d0, 1);
            check_eq("w8_queue_empty", 64'(q8.size()), 0);
            check_eq("w8_in_ready", in_ready8, 1);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/outdata.md
Name: outdata

Overview:
- Transmit-side serializer for the floating-point multiplier datapath.
- Accepts one 32-bit product word (Result) with a single-cycle DataValid strobe.
- Emits the word as NUM_BYTES bytes, most significant byte first, over a valid/ready byte interface toward the UART transmitter.
- Mirror of the byte-collecting input stage: same byte order, the host reads back the same framing it writes.

Parameters:
NUM_BYTES, 4, bytes per word; Result width is 8*NUM_BYTES; legal values 2..16.

Ports:
clk  in  1  rising-edge system clock
rst  in  1  synchronous, active-high reset
DataValid  in  1  one-cycle strobe, Result valid; honoured only when in_ready=1
Result  in  8*NUM_BYTES  word to send; sampled on the accepting edge only
in_ready  out  1  1 when idle and able to accept a word
tx_data  out  8  current byte
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  downstream accepts the byte on an edge where tx_valid&tx_ready
tx_last  out  1  1 while the final byte of a word is presented
done  out  1  one-cycle pulse after the last byte is accepted
overrun  out  1  sticky; DataValid arrived while in_ready=0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All state is updated on the rising edge of clk only.
- Reset values: state=IDLE, byte index=0, shift register=0, tx_data=0, tx_valid=0, tx_last=0, done=0, overrun=0. in_ready is decoded from state, so it reads 1 once reset deasserts.
- States:
  - IDLE: in_ready=1, tx_valid=0. On DataValid=1, latch Result into the shift register, set index=0 and go to SEND.
  - SEND: in_ready=0, tx_valid=1, tx_data = byte[index], where byte 0 = Result[8*NUM_BYTES-1 -: 8].
    - On an edge with tx_ready=1: index increments.
    - If index was NUM_BYTES-1: return to IDLE, drop tx_valid and pulse done=1 for one cycle.
- Latency:
  - DataValid sampled at edge N: first byte presented from cycle N+1.
  - With tx_ready tied high, one byte per cycle. Last accept at edge N+NUM_BYTES; done=1 and in_ready=1 in the following cycle.
- Handshake rules:
  - tx_data and tx_last must stay stable while tx_valid=1 and tx_ready=0.
  - tx_ready stalls of any length are legal.
  - tx_ready while tx_valid=0 is ignored.
- tx_last = (state==SEND) && (index==NUM_BYTES-1).
- Overrun:
  - DataValid while in_ready=0 is dropped, including the cycle of the last byte's accept. The word in flight is unaffected.
  - overrun sets to 1 and holds until rst.
- DataValid and rst asserted together: reset wins and nothing is latched.
- Reset mid-word: transmission aborts at once. tx_valid drops the cycle after the reset edge, no done pulse is issued, and the partial word is discarded.
- Index counter width is clog2(NUM_BYTES). No wrap occurs beyond NUM_BYTES-1, since the block leaves SEND on that accept.
- done and DataValid in the same cycle (IDLE): the new word is accepted normally.

Test Plan:
- Basic, NUM_BYTES=4, tx_ready=1: Result=32'h3FC00000 with DataValid pulse -> tx_data 3F,C0,00,00 on consecutive cycles; tx_last only on 00 (4th); done one cycle later; in_ready back to 1.
- Backpressure: Result=32'hC1480000, tx_ready low for 5 cycles on each byte -> each byte held stable while stalled; order C1,48,00,00; exactly 4 accepts; one done pulse.
- Overrun: DataValid with 32'h11223344 during the 2nd byte of 32'hAABBCCDD -> output AA,BB,CC,DD only; overrun=1 and stays 1; next word after done is sent correctly.
- Reset mid-word: assert rst after 2 of 4 bytes of 32'h01020304 -> tx_valid=0, overrun=0, no done; new word 32'h0A0B0C0D then sends 0A,0B,0C,0D.
- Back-to-back: DataValid asserted in the done cycle with 32'h40490FDB -> accepted; bytes 40,49,0F,DB follow with no gap beyond one cycle.
- Parameter: NUM_BYTES=8, Result=64'h0123456789ABCDEF -> 8 bytes 01..EF in order; tx_last on EF only.
